stage2_n_type_scatter: RTL and testbench
========================================

# stage2_N_type_scatter

Write-back distributor for stage 2. Each beat carries one N-type message per lane (lanes 1–3) and a per-lane N-type control code. The block registers the beat and routes each lane's message to exactly one of five destination banks (L, M, N, R, S), each with its own per-lane write-address counter. It is the inverse of the stage-2 N-type selection path: it writes the banks that the selector later reads.

## Interface
Parameters:
- ADDR_BITS, default 6: per-bank, per-lane address width; depth is 2^ADDR_BITS.
- ERR_BITS, default 8: width of the invalid-code counter.

Ports:
- clk  input  1  system clock; single clock domain.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  beat accepted when in_valid && in_ready.
- in_first  input  1  beat is the first of a frame.
- in_last  input  1  beat is the last of a frame.
- message_N_1/2/3  input  `MAX_MESSAGE_BITS  lane messages.
- N_type_control_m1/2/3  input  `N_type_control_width  lane destination code.
- dst_stall  input  1  banks cannot accept writes this cycle.
- message_NX_k (X∈L,M,N,R,S; k∈1..3)  output  `MAX_MESSAGE_BITS  registered write data.
- we_NX (X∈L,M,N,R,S)  output  3  per-lane write enable; bit k-1 = lane k.
- addr_NX_k  output  ADDR_BITS  write address for bank X, lane k.
- frame_done  output  1  one-cycle pulse after the last beat commits.
- addr_ovf  output  1  sticky flag: some address counter wrapped.
- err_count  output  ERR_BITS  saturating count of invalid lane codes.

## Operation
- A single output stage holds one beat: stage_valid plus the registered messages, codes, first and last.
- Accept:
  - in_ready = !rst && (!stage_valid || !dst_stall).
  - On acceptance the stage loads. Otherwise, if a commit occurs, stage_valid clears.
- Commit = stage_valid && !dst_stall.
  - For each lane k, decode the code: `N_type_L/M/N/R/S select bank X, and we_NX[k-1]=1 only during commit.
  - Any other code drops the lane: no enable, err_count increments.
- Data: message_NX_k always drives the staged lane-k message for all X. Only the enables qualify it.
- Address counters: cnt_X_k for each of the 15 (bank, lane) pairs.
  - addr_NX_k = 0 if the staged beat is first, else cnt_X_k.
  - On a commit that writes (X,k): cnt_X_k ← addr_NX_k + 1, modulo 2^ADDR_BITS.
  - On a commit of a first beat, every counter not written is cleared to 0.
  - A wrap from all-ones to 0 sets addr_ovf. addr_ovf clears only on reset or on a first-beat commit.
- err_count adds the number of invalid lanes (0–3) per commit and saturates at all-ones. It never clears except on reset.
- frame_done is asserted in the cycle after a commit of a beat with last set. A single beat may have both first and last set.

## Timing
- Reset (synchronous): stage_valid=0, all we_NX=0, counters=0, err_count=0, addr_ovf=0, frame_done=0, in_ready=0 while rst is high. Message outputs are 0.
- Latency: a beat accepted at edge t drives enables in cycle t+1 when dst_stall=0. Throughput is 1 beat/cycle.
- Stall: while dst_stall=1, the stage holds, enables stay 0, and counters hold. A new beat is accepted only if the stage is empty.
- Simultaneous commit and accept: the old beat commits and the new beat loads at the same edge.
- Reset mid-frame discards the staged beat. No enable is asserted in the reset cycle.

## Structure
- para_def.v (shared include) holds the existing `MAX_MESSAGE_BITS, `N_type_control_width and `N_type_L/M/N/R/S.
- Add to para_def.v: `N_type_banks (5).
- Sub-module stage2_N_type_scatter_lane, instantiated 3 times. It contains the code decode, the 5 address counters, the wrap detection and the invalid flag for one lane. The top level owns the stage register, the handshake, err_count and frame_done.

## Test plan
- First beat with codes L, M, S and dst_stall=0: one cycle later we_NL=001, we_NM=010, we_NS=100, all three addresses 0. Following beat with codes L, L, L: we_NL=111, addr_NL_1=1, addr_NL_2=0, addr_NL_3=0.
- Stream of 4 beats with dst_stall high for cycles 2–3: in_ready drops while the stage is full, no enables assert during the stall, and all 4 writes commit in order with contiguous addresses.
- Lane 2 code invalid on 300 consecutive beats (ERR_BITS=8): lane 2 is never enabled and err_count saturates at 255.
- ADDR_BITS=2, 5 beats to bank R on lane 1: addresses 0, 1, 2, 3, 0, and addr_ovf sets on the 4th commit. The next first beat clears it.
- Beat with first and last both set: addresses 0 and frame_done pulses exactly one cycle after the commit.
- rst asserted while the stage is full: no enable that cycle, all counters 0, and the next first beat writes address 0.

Source files
------------

// File: rtl/stage2_n_type_scatter_pkg.sv
// Shared constants and types for the stage-2 N-type write-back distributor.
// Holds the message/control widths, bank count and the destination codes.
package stage2_n_type_scatter_pkg;

  localparam int MAX_MESSAGE_BITS     = 16;
  localparam int N_TYPE_CONTROL_WIDTH = 3;
  localparam int N_TYPE_BANKS         = 5;
  localparam int N_LANES              = 3;

  typedef logic [MAX_MESSAGE_BITS-1:0]     msg_t;
  typedef logic [N_TYPE_CONTROL_WIDTH-1:0] code_t;

  typedef enum logic [N_TYPE_CONTROL_WIDTH-1:0] {
    N_TYPE_L = 3'd0,
    N_TYPE_M = 3'd1,
    N_TYPE_N = 3'd2,
    N_TYPE_R = 3'd3,
    N_TYPE_S = 3'd4
  } n_type_code_e;

  // One-hot bank select in L,M,N,R,S order; all-zero marks an invalid code.
  function automatic logic [N_TYPE_BANKS-1:0] decode_code(input code_t code);
    logic [N_TYPE_BANKS-1:0] sel;
    case (code)
      N_TYPE_L: sel = 5'b00001;
      N_TYPE_M: sel = 5'b00010;
      N_TYPE_N: sel = 5'b00100;
      N_TYPE_R: sel = 5'b01000;
      N_TYPE_S: sel = 5'b10000;
      default:  sel = 5'b00000;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/stage2_n_type_scatter_lane.sv
// One lane of the N-type scatter: code decode, five bank address counters,
// wrap detection and invalid-code flag.
module stage2_n_type_scatter_lane
  import stage2_n_type_scatter_pkg::*;
#(
  parameter int ADDR_BITS = 6
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    i_commit,
  input  logic                                    i_first,
  input  logic [N_TYPE_CONTROL_WIDTH-1:0]         i_code,
  output logic [N_TYPE_BANKS-1:0]                 o_we,
  output logic [N_TYPE_BANKS-1:0][ADDR_BITS-1:0]  o_addr,
  output logic                                    o_wrap,
  output logic                                    o_invalid
);

  logic [N_TYPE_BANKS-1:0]                w_sel;
  logic [N_TYPE_BANKS-1:0][ADDR_BITS-1:0] r_cnt;

  assign w_sel     = decode_code(i_code);
  assign o_invalid = ~|w_sel;

  // A first beat restarts every bank at address 0.
  always_comb begin
    o_wrap = 1'b0;
    for (int b = 0; b < N_TYPE_BANKS; b++) begin
      o_addr[b] = i_first ? '0 : r_cnt[b];
      o_we[b]   = i_commit & w_sel[b];
      if (o_we[b] && (&o_addr[b])) o_wrap = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_commit) begin
      for (int b = 0; b < N_TYPE_BANKS; b++) begin
        if (w_sel[b])     r_cnt[b] <= o_addr[b] + ADDR_BITS'(1);
        else if (i_first) r_cnt[b] <= '0;
      end
    end
  end

endmodule

// File: rtl/stage2_n_type_scatter.sv
// Stage-2 N-type write-back distributor: one-beat output stage that routes
// each lane's message to one of the L/M/N/R/S banks with per-lane addresses.
module stage2_n_type_scatter
  import stage2_n_type_scatter_pkg::*;
#(
  parameter int ADDR_BITS = 6,
  parameter int ERR_BITS  = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic                            in_first,
  input  logic                            in_last,
  input  logic [MAX_MESSAGE_BITS-1:0]     message_N_1,
  input  logic [MAX_MESSAGE_BITS-1:0]     message_N_2,
  input  logic [MAX_MESSAGE_BITS-1:0]     message_N_3,
  input  logic [N_TYPE_CONTROL_WIDTH-1:0] N_type_control_m1,
  input  logic [N_TYPE_CONTROL_WIDTH-1:0] N_type_control_m2,
  input  logic [N_TYPE_CONTROL_WIDTH-1:0] N_type_control_m3,
  input  logic                            dst_stall,
  output logic [MAX_MESSAGE_BITS-1:0]     message_NL_1, message_NL_2, message_NL_3,
  output logic [MAX_MESSAGE_BITS-1:0]     message_NM_1, message_NM_2, message_NM_3,
  output logic [MAX_MESSAGE_BITS-1:0]     message_NN_1, message_NN_2, message_NN_3,
  output logic [MAX_MESSAGE_BITS-1:0]     message_NR_1, message_NR_2, message_NR_3,
  output logic [MAX_MESSAGE_BITS-1:0]     message_NS_1, message_NS_2, message_NS_3,
  output logic [N_LANES-1:0]              we_NL, we_NM, we_NN, we_NR, we_NS,
  output logic [ADDR_BITS-1:0]            addr_NL_1, addr_NL_2, addr_NL_3,
  output logic [ADDR_BITS-1:0]            addr_NM_1, addr_NM_2, addr_NM_3,
  output logic [ADDR_BITS-1:0]            addr_NN_1, addr_NN_2, addr_NN_3,
  output logic [ADDR_BITS-1:0]            addr_NR_1, addr_NR_2, addr_NR_3,
  output logic [ADDR_BITS-1:0]            addr_NS_1, addr_NS_2, addr_NS_3,
  output logic                            frame_done,
  output logic                            addr_ovf,
  output logic [ERR_BITS-1:0]             err_count
);

  localparam logic [ERR_BITS+1:0] ERR_MAX = {2'b00, {ERR_BITS{1'b1}}};

  msg_t  r_msg  [N_LANES];
  code_t r_code [N_LANES];
  logic  r_stage_valid, r_first, r_last;
  logic  r_frame_done, r_ovf;
  logic [ERR_BITS-1:0] r_err;

  msg_t  w_in_msg  [N_LANES];
  code_t w_in_code [N_LANES];
  logic  w_commit, w_accept;
  logic [N_LANES-1:0] w_wrap, w_invalid;
  logic [1:0]          w_inv_count;
  logic [ERR_BITS+1:0] w_err_sum;
  logic [ERR_BITS-1:0] w_err_next;
  logic [N_TYPE_BANKS-1:0]                w_we   [N_LANES];
  logic [N_TYPE_BANKS-1:0][ADDR_BITS-1:0] w_addr [N_LANES];

  assign w_in_msg[0]  = message_N_1;
  assign w_in_msg[1]  = message_N_2;
  assign w_in_msg[2]  = message_N_3;
  assign w_in_code[0] = N_type_control_m1;
  assign w_in_code[1] = N_type_control_m2;
  assign w_in_code[2] = N_type_control_m3;

  // Reset gates the commit so no enable can fire in the reset cycle.
  assign in_ready = ~rst & (~r_stage_valid | ~dst_stall);
  assign w_accept = in_valid & in_ready;
  assign w_commit = r_stage_valid & ~dst_stall & ~rst;

  assign w_inv_count = w_commit ? ({1'b0, w_invalid[0]} + {1'b0, w_invalid[1]}
                                   + {1'b0, w_invalid[2]}) : 2'd0;
  assign w_err_sum   = {2'b00, r_err} + {{ERR_BITS{1'b0}}, w_inv_count};
  assign w_err_next  = (w_err_sum > ERR_MAX) ? {ERR_BITS{1'b1}} : w_err_sum[ERR_BITS-1:0];

  for (genvar k = 0; k < N_LANES; k++) begin : g_lane
    stage2_n_type_scatter_lane #(.ADDR_BITS(ADDR_BITS)) u_lane (
      .clk       (clk),
      .rst       (rst),
      .i_commit  (w_commit),
      .i_first   (r_first),
      .i_code    (r_code[k]),
      .o_we      (w_we[k]),
      .o_addr    (w_addr[k]),
      .o_wrap    (w_wrap[k]),
      .o_invalid (w_invalid[k])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stage_valid <= 1'b0;
      r_first       <= 1'b0;
      r_last        <= 1'b0;
      r_frame_done  <= 1'b0;
      r_ovf         <= 1'b0;
      r_err         <= '0;
      for (int k = 0; k < N_LANES; k++) begin
        r_msg[k]  <= '0;
        r_code[k] <= '0;
      end
    end else begin
      if (w_accept) begin
        r_stage_valid <= 1'b1;
        r_first       <= in_first;
        r_last        <= in_last;
        for (int k = 0; k < N_LANES; k++) begin
          r_msg[k]  <= w_in_msg[k];
          r_code[k] <= w_in_code[k];
        end
      end else if (w_commit) begin
        r_stage_valid <= 1'b0;
      end
      r_frame_done <= w_commit & r_last;
      r_ovf        <= (r_ovf & ~(w_commit & r_first)) | (|w_wrap);
      r_err        <= w_err_next;
    end
  end

  assign frame_done = r_frame_done;
  assign addr_ovf   = r_ovf;
  assign err_count  = r_err;

  assign we_NL = {w_we[2][0], w_we[1][0], w_we[0][0]};
  assign we_NM = {w_we[2][1], w_we[1][1], w_we[0][1]};
  assign we_NN = {w_we[2][2], w_we[1][2], w_we[0][2]};
  assign we_NR = {w_we[2][3], w_we[1][3], w_we[0][3]};
  assign we_NS = {w_we[2][4], w_we[1][4], w_we[0][4]};

  assign addr_NL_1 = w_addr[0][0];  assign addr_NL_2 = w_addr[1][0];  assign addr_NL_3 = w_addr[2][0];
  assign addr_NM_1 = w_addr[0][1];  assign addr_NM_2 = w_addr[1][1];  assign addr_NM_3 = w_addr[2][1];
  assign addr_NN_1 = w_addr[0][2];  assign addr_NN_2 = w_addr[1][2];  assign addr_NN_3 = w_addr[2][2];
  assign addr_NR_1 = w_addr[0][3];  assign addr_NR_2 = w_addr[1][3];  assign addr_NR_3 = w_addr[2][3];
  assign addr_NS_1 = w_addr[0][4];  assign addr_NS_2 = w_addr[1][4];  assign addr_NS_3 = w_addr[2][4];

  assign message_NL_1 = r_msg[0];  assign message_NL_2 = r_msg[1];  assign message_NL_3 = r_msg[2];
  assign message_NM_1 = r_msg[0];  assign message_NM_2 = r_msg[1];  assign message_NM_3 = r_msg[2];
  assign message_NN_1 = r_msg[0];  assign message_NN_2 = r_msg[1];  assign message_NN_3 = r_msg[2];
  assign message_NR_1 = r_msg[0];  assign message_NR_2 = r_msg[1];  assign message_NR_3 = r_msg[2];
  assign message_NS_1 = r_msg[0];  assign message_NS_2 = r_msg[1];  assign message_NS_3 = r_msg[2];

endmodule

// File: tb/tb_stage2_n_type_scatter.sv
// Randomized bench for stage2_n_type_scatter with an in-bench behavioural
// model of the beat stage, bank counters, overflow flag and error counter.
module tb_stage2_n_type_scatter;
  import stage2_n_type_scatter_pkg::*;

  localparam int ADDR_BITS = 2;
  localparam int ERR_BITS  = 8;
  localparam int DEPTH     = 1 << ADDR_BITS;
  localparam int ERR_MAX   = (1 << ERR_BITS) - 1;

  logic clk, rst, inValid, inFirst, inLast, dstStall;
  logic inReady, frameDone, addrOvf;
  logic [ERR_BITS-1:0] errCount;
  logic [MAX_MESSAGE_BITS-1:0] inMsg [3];
  logic [2:0] inCode [3];
  logic [2:0] dutWe [5];
  logic [ADDR_BITS-1:0] dutAddr [5][3];
  logic [MAX_MESSAGE_BITS-1:0] dutMsg [5][3];

  int checks = 0;
  int failures = 0;
  bit checkEn = 0;

  // Behavioural model state: banks indexed 0..4 = L,M,N,R,S.
  bit stVal, stFirst, stLast, ovf, fdone;
  logic [MAX_MESSAGE_BITS-1:0] stMsg [3];
  logic [2:0] stCode [3];
  int cnt [5][3];
  int err;

  stage2_n_type_scatter #(.ADDR_BITS(ADDR_BITS), .ERR_BITS(ERR_BITS)) dut (
    .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReady),
    .in_first(inFirst), .in_last(inLast),
    .message_N_1(inMsg[0]), .message_N_2(inMsg[1]), .message_N_3(inMsg[2]),
    .N_type_control_m1(inCode[0]), .N_type_control_m2(inCode[1]), .N_type_control_m3(inCode[2]),
    .dst_stall(dstStall),
    .message_NL_1(dutMsg[0][0]), .message_NL_2(dutMsg[0][1]), .message_NL_3(dutMsg[0][2]),
    .message_NM_1(dutMsg[1][0]), .message_NM_2(dutMsg[1][1]), .message_NM_3(dutMsg[1][2]),
    .message_NN_1(dutMsg[2][0]), .message_NN_2(dutMsg[2][1]), .message_NN_3(dutMsg[2][2]),
    .message_NR_1(dutMsg[3][0]), .message_NR_2(dutMsg[3][1]), .message_NR_3(dutMsg[3][2]),
    .message_NS_1(dutMsg[4][0]), .message_NS_2(dutMsg[4][1]), .message_NS_3(dutMsg[4][2]),
    .we_NL(dutWe[0]), .we_NM(dutWe[1]), .we_NN(dutWe[2]), .we_NR(dutWe[3]), .we_NS(dutWe[4]),
    .addr_NL_1(dutAddr[0][0]), .addr_NL_2(dutAddr[0][1]), .addr_NL_3(dutAddr[0][2]),
    .addr_NM_1(dutAddr[1][0]), .addr_NM_2(dutAddr[1][1]), .addr_NM_3(dutAddr[1][2]),
    .addr_NN_1(dutAddr[2][0]), .addr_NN_2(dutAddr[2][1]), .addr_NN_3(dutAddr[2][2]),
    .addr_NR_1(dutAddr[3][0]), .addr_NR_2(dutAddr[3][1]), .addr_NR_3(dutAddr[3][2]),
    .addr_NS_1(dutAddr[4][0]), .addr_NS_2(dutAddr[4][1]), .addr_NS_3(dutAddr[4][2]),
    .frame_done(frameDone), .addr_ovf(addrOvf), .err_count(errCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int bankOf(input logic [2:0] c);
    case (c)
      N_TYPE_L: return 0;
      N_TYPE_M: return 1;
      N_TYPE_N: return 2;
      N_TYPE_R: return 3;
      N_TYPE_S: return 4;
      default:  return -1;
    endcase
  endfunction

  task automatic checkVal(input string name, input int b, input int k,
                          input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (b >= 0)
        $display("[TB] FAIL %s[bank %0d][lane %0d] at %0t: got %0h expected %0h", name, b, k + 1, $time, act, exp);
      else
        $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs the DUT sees.
  task automatic modelStep();
    bit commit, accept, wrapSeen;
    int a [3];
    int nInv, bk;
    if (rst) begin
      stVal = 0; stFirst = 0; stLast = 0; ovf = 0; fdone = 0; err = 0;
      for (int k = 0; k < 3; k++) begin stMsg[k] = '0; stCode[k] = '0; end
      for (int b = 0; b < 5; b++) for (int k = 0; k < 3; k++) cnt[b][k] = 0;
    end else begin
      commit = stVal && !dstStall;
      accept = inValid && (!stVal || !dstStall);
      fdone  = commit && stLast;
      if (commit) begin
        nInv = 0; wrapSeen = 0;
        for (int k = 0; k < 3; k++) begin
          a[k] = 0;
          bk = bankOf(stCode[k]);
          if (bk < 0) nInv++;
          else begin
            a[k] = stFirst ? 0 : cnt[bk][k];
            if (a[k] == DEPTH - 1) wrapSeen = 1;
          end
        end
        if (stFirst) for (int b = 0; b < 5; b++) for (int k = 0; k < 3; k++) cnt[b][k] = 0;
        for (int k = 0; k < 3; k++) begin
          bk = bankOf(stCode[k]);
          if (bk >= 0) cnt[bk][k] = (a[k] + 1) % DEPTH;
        end
        ovf = (stFirst ? 1'b0 : ovf) | wrapSeen;
        err = (err + nInv > ERR_MAX) ? ERR_MAX : err + nInv;
      end
      if (accept) begin
        stVal = 1; stFirst = inFirst; stLast = inLast;
        stMsg = inMsg; stCode = inCode;
      end else if (commit) begin
        stVal = 0;
      end
    end
  endtask

  always @(posedge clk) modelStep();

  task automatic checkOutput();
    bit commit;
    logic [2:0] ew;
    commit = stVal && !dstStall && !rst;
    for (int b = 0; b < 5; b++) begin
      for (int k = 0; k < 3; k++) begin
        ew[k] = commit && (bankOf(stCode[k]) == b);
        checkVal("addr", b, k, 32'(dutAddr[b][k]), stFirst ? 32'd0 : 32'(cnt[b][k]));
        checkVal("msg", b, k, 32'(dutMsg[b][k]), 32'(stMsg[k]));
      end
      checkVal("we", b, 0, 32'(dutWe[b]), 32'(ew));
    end
    checkVal("in_ready", -1, -1, 32'(inReady), 32'(!rst && (!stVal || !dstStall)));
    checkVal("frame_done", -1, -1, 32'(frameDone), 32'(fdone));
    checkVal("addr_ovf", -1, -1, 32'(addrOvf), 32'(ovf));
    checkVal("err_count", -1, -1, 32'(errCount), 32'(err));
  endtask

  always @(negedge clk) if (checkEn) checkOutput();

  // Drive one cycle of inputs shortly after the rising edge.
  task automatic applyStimulus(input bit r, input bit v, input bit f, input bit l,
                               input bit stall, input logic [2:0] c0,
                               input logic [2:0] c1, input logic [2:0] c2);
    @(posedge clk);
    #2;
    rst = r; inValid = v; inFirst = f; inLast = l; dstStall = stall;
    inCode[0] = c0; inCode[1] = c1; inCode[2] = c2;
    for (int k = 0; k < 3; k++) inMsg[k] = MAX_MESSAGE_BITS'($urandom);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 3'd0, 3'd0, 3'd0);
  endtask

  initial begin
    rst = 1; inValid = 0; inFirst = 0; inLast = 0; dstStall = 0;
    for (int k = 0; k < 3; k++) begin inMsg[k] = '0; inCode[k] = '0; end
    repeat (3) applyStimulus(1, 0, 0, 0, 0, 3'd0, 3'd0, 3'd0);
    checkEn = 1;
    @(negedge clk);
    checkVal("reset in_ready", -1, -1, 32'(inReady), 32'd0);
    checkVal("reset err_count", -1, -1, 32'(errCount), 32'd0);
    idle(2);

    // First beat L,M,S then L,L,L.
    applyStimulus(0, 1, 1, 0, 0, N_TYPE_L, N_TYPE_M, N_TYPE_S);
    applyStimulus(0, 1, 0, 0, 0, N_TYPE_L, N_TYPE_L, N_TYPE_L);
    @(negedge clk);
    checkVal("lit we_NL", -1, -1, 32'(dutWe[0]), 32'b001);
    checkVal("lit we_NM", -1, -1, 32'(dutWe[1]), 32'b010);
    checkVal("lit we_NS", -1, -1, 32'(dutWe[4]), 32'b100);
    checkVal("lit addr_NM_2", -1, -1, 32'(dutAddr[1][1]), 32'd0);
    checkVal("lit addr_NS_3", -1, -1, 32'(dutAddr[4][2]), 32'd0);
    idle(1);
    @(negedge clk);
    checkVal("lit we_NL all", -1, -1, 32'(dutWe[0]), 32'b111);
    checkVal("lit addr_NL_1", -1, -1, 32'(dutAddr[0][0]), 32'd1);
    checkVal("lit addr_NL_2", -1, -1, 32'(dutAddr[0][1]), 32'd0);
    checkVal("lit addr_NL_3", -1, -1, 32'(dutAddr[0][2]), 32'd0);
    idle(2);

    // Four-beat stream with a two-cycle stall.
    applyStimulus(0, 1, 1, 0, 0, N_TYPE_N, N_TYPE_N, N_TYPE_N);
    applyStimulus(0, 1, 0, 0, 1, N_TYPE_N, N_TYPE_N, N_TYPE_N);
    @(negedge clk);
    checkVal("lit stall in_ready", -1, -1, 32'(inReady), 32'd0);
    checkVal("lit stall we_NN", -1, -1, 32'(dutWe[2]), 32'd0);
    applyStimulus(0, 1, 0, 0, 1, N_TYPE_N, N_TYPE_N, N_TYPE_N);
    applyStimulus(0, 1, 0, 0, 0, N_TYPE_N, N_TYPE_N, N_TYPE_N);
    applyStimulus(0, 1, 0, 0, 0, N_TYPE_N, N_TYPE_N, N_TYPE_N);
    applyStimulus(0, 1, 0, 1, 0, N_TYPE_N, N_TYPE_N, N_TYPE_N);
    idle(3);

    // Wrap on bank R lane 1 with a 4-deep address space.
    applyStimulus(0, 1, 1, 0, 0, N_TYPE_R, N_TYPE_M, N_TYPE_L);
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 0, 0, 0, N_TYPE_R, N_TYPE_M, N_TYPE_L);
    @(negedge clk);
    checkVal("lit wrap addr 3", -1, -1, 32'(dutAddr[3][0]), 32'd3);
    checkVal("lit ovf before wrap", -1, -1, 32'(addrOvf), 32'd0);
    idle(1);
    @(negedge clk);
    checkVal("lit wrap addr 0", -1, -1, 32'(dutAddr[3][0]), 32'd0);
    checkVal("lit ovf set", -1, -1, 32'(addrOvf), 32'd1);
    applyStimulus(0, 1, 1, 0, 0, N_TYPE_S, N_TYPE_S, N_TYPE_S);
    idle(2);
    @(negedge clk);
    checkVal("lit ovf cleared", -1, -1, 32'(addrOvf), 32'd0);

    // Single-beat frame.
    applyStimulus(0, 1, 1, 1, 0, N_TYPE_M, N_TYPE_M, N_TYPE_M);
    idle(1);
    @(negedge clk);
    checkVal("lit frame_done early", -1, -1, 32'(frameDone), 32'd0);
    idle(1);
    @(negedge clk);
    checkVal("lit frame_done pulse", -1, -1, 32'(frameDone), 32'd1);
    idle(1);
    @(negedge clk);
    checkVal("lit frame_done drop", -1, -1, 32'(frameDone), 32'd0);

    // Reset while the stage is full, then a non-first beat starts at 0.
    applyStimulus(0, 1, 0, 0, 0, N_TYPE_L, N_TYPE_L, N_TYPE_L);
    applyStimulus(0, 0, 0, 0, 1, N_TYPE_L, N_TYPE_L, N_TYPE_L);
    applyStimulus(1, 1, 0, 0, 0, N_TYPE_L, N_TYPE_L, N_TYPE_L);
    @(negedge clk);
    checkVal("lit reset we_NL", -1, -1, 32'(dutWe[0]), 32'd0);
    applyStimulus(0, 1, 0, 0, 0, N_TYPE_L, N_TYPE_L, N_TYPE_L);
    idle(1);
    @(negedge clk);
    checkVal("lit post-reset addr_NL_1", -1, -1, 32'(dutAddr[0][0]), 32'd0);
    checkVal("lit post-reset we_NL", -1, -1, 32'(dutWe[0]), 32'b111);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++)
      applyStimulus($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 7,
                    $urandom_range(0, 6) == 0, $urandom_range(0, 6) == 0,
                    $urandom_range(0, 9) < 3, 3'($urandom_range(0, 7)),
                    3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    idle(2);

    // Lane 2 invalid for 300 beats saturates the error counter.
    for (int i = 0; i < 300; i++)
      applyStimulus(0, 1, i == 0, 0, 0, 3'($urandom_range(0, 4)), 3'd7,
                    3'($urandom_range(0, 4)));
    idle(3);
    @(negedge clk);
    checkVal("lit err saturated", -1, -1, 32'(errCount), 32'd255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
